// File: rtl/clk_phase_gen.sv
// Multiphase clock-enable generator: a self-correcting Johnson counter advanced by a
// runtime prescaler, with a frame strobe and a frame-aligned downstream reset release.
module clk_phase_gen #(
    parameter int NUM_PHASES = 2,
    parameter int PRESCALE_W = 4,
    parameter int RST_HOLD   = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic [NUM_PHASES-1:0] phase_o,
    output logic                  frame_o,
    output logic                  rst_o,
    output logic                  locked_o
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    // Selects the NUM_PHASES-1 adjacent-bit pairs of the Johnson register.
    localparam logic [NUM_PHASES-1:0] INNER_PAIRS = {NUM_PHASES{1'b1}} >> 1;

    logic [PRESCALE_W-1:0] pcnt;
    logic [PRESCALE_W-1:0] psc_q;
    logic [NUM_PHASES-1:0] j;
    logic [NUM_PHASES-1:0] j_next;
    logic [HOLD_W-1:0]     hold;
    logic                  tick;
    logic                  boundary;
    logic                  legal;

    assign tick     = en_i && (pcnt == psc_q);
    assign boundary = tick && (j == '0);

    // A thermometer code from either end has at most one transition between adjacent bits.
    assign legal = ($countones((j ^ (j >> 1)) & INNER_PAIRS) <= 1);

    // NOTE: combinational blocks assign every output before any conditional logic, so no latch can be inferred.
    always_comb begin
        j_next    = '0;
        j_next[0] = ~j[NUM_PHASES-1];
        for (int k = 1; k < NUM_PHASES; k++) begin
            j_next[k] = j[k-1];
        end
    end

    // NOTE: all state updates are non-blocking so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt     <= '0;
            psc_q    <= prescale_i;
            j        <= '0;
            hold     <= '0;
            frame_o  <= 1'b0;
            rst_o    <= 1'b1;
            locked_o <= 1'b0;
        end else if (!legal) begin
            // Upset recovery restarts the sequence; the downstream reset is left alone.
            j        <= '0;
            pcnt     <= '0;
            frame_o  <= 1'b0;
            locked_o <= 1'b0;
        end else begin
            frame_o <= boundary;
            if (tick) begin
                pcnt <= '0;
                j    <= j_next;
            end else if (en_i) begin
                pcnt <= pcnt + 1'b1;
            end
            if (boundary) begin
                psc_q <= prescale_i;
                if (rst_o) begin
                    if (hold == HOLD_LAST) begin
                        rst_o    <= 1'b0;
                        locked_o <= 1'b1;
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end else begin
                    locked_o <= 1'b1;
                end
            end
        end
    end

    assign phase_o = j;

endmodule

// File: tb/tb_clk_phase_gen.sv
// Self-checking bench for clk_phase_gen: three instances (2, 3 and 4 phases) share one
// stimulus stream; a step-index reference model feeds a scoreboard, plus table and corner checks.
module tb_clk_phase_gen;

    localparam int RST_HOLD = 3;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       en_i  = 1'b0;
    logic [3:0] prescale_i = '0;

    logic [1:0] ph2;
    logic [2:0] ph3;
    logic [3:0] ph4;
    logic       fr2, rs2, lk2, fr3, rs3, lk3, fr4, rs4, lk4;

    always #5 clk_i = ~clk_i;

    clk_phase_gen #(.NUM_PHASES(2), .PRESCALE_W(4), .RST_HOLD(RST_HOLD)) u_d2 (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .prescale_i(prescale_i),
        .phase_o(ph2), .frame_o(fr2), .rst_o(rs2), .locked_o(lk2));
    clk_phase_gen #(.NUM_PHASES(3), .PRESCALE_W(4), .RST_HOLD(RST_HOLD)) u_d3 (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .prescale_i(prescale_i),
        .phase_o(ph3), .frame_o(fr3), .rst_o(rs3), .locked_o(lk3));
    clk_phase_gen #(.NUM_PHASES(4), .PRESCALE_W(4), .RST_HOLD(RST_HOLD)) u_d4 (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .prescale_i(prescale_i),
        .phase_o(ph4), .frame_o(fr4), .rst_o(rs4), .locked_o(lk4));

    // Reference model: s = steps taken within the 2N-step period, pc = cycles within a step.
    typedef struct {
        int pc;
        int psc;
        int s;
        bit frame;
        bit rst;
        bit locked;
        int frames;
    } mdl_t;

    typedef struct {
        int         inst;
        logic [7:0] ph;
        bit         fr;
        bit         rs;
        bit         lk;
    } exp_t;

    typedef struct {
        bit         rst;
        bit         en;
        int         psc;
        logic [1:0] ph;
        bit         fr;
        bit         rs;
        bit         lk;
    } vec_t;

    mdl_t m2, m3, m4;
    exp_t exp_q[$];
    int   fr2_t[$];
    int   fr4_t[$];
    int   errors = 0;
    int   checks = 0;
    int   edge_no = -1;
    vec_t vecs[11];

    function automatic mdl_t mdl_step(mdl_t m, int n, bit r, bit e, int p, bit bad);
        mdl_t o = m;
        if (r) begin
            o.pc = 0; o.psc = p; o.s = 0; o.frame = 0;
            o.rst = 1; o.locked = 0; o.frames = 0;
        end else if (bad) begin
            o.pc = 0; o.s = 0; o.frame = 0; o.locked = 0;
        end else begin
            o.frame = 0;
            if (e) begin
                if (m.pc == m.psc) begin
                    o.pc = 0;
                    if (m.s == 0) begin
                        o.frame = 1;
                        o.psc = p;
                        if (m.rst) begin
                            o.frames = m.frames + 1;
                            if (o.frames == RST_HOLD) begin
                                o.rst = 0;
                                o.locked = 1;
                            end
                        end else begin
                            o.locked = 1;
                        end
                    end
                    o.s = (m.s + 1) % (2 * n);
                end else begin
                    o.pc = m.pc + 1;
                end
            end
        end
        return o;
    endfunction

    // Bit k is high during steps k+1 .. k+n of each 2n-step period.
    function automatic logic [7:0] mdl_phase(int s, int n);
        logic [7:0] v = '0;
        for (int k = 0; k < n; k++) begin
            v[k] = (((s - k - 1 + 2 * n) % (2 * n)) < n);
        end
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    function automatic exp_t mk_exp(int inst, mdl_t m, int n);
        exp_t x;
        x.inst = inst;
        x.ph   = mdl_phase(m.s, n);
        x.fr   = m.frame;
        x.rs   = m.rst;
        x.lk   = m.locked;
        return x;
    endfunction

    task automatic cycle(input bit r, input bit e, input int p, input bit inj3);
        exp_t x;
        @(negedge clk_i);
        rst_i      = r;
        en_i       = e;
        prescale_i = p[3:0];
        if (inj3) begin
            force u_d3.j = 3'b101;
            #1;
            release u_d3.j;
        end
        m2 = mdl_step(m2, 2, r, e, p, 1'b0);
        m3 = mdl_step(m3, 3, r, e, p, inj3);
        m4 = mdl_step(m4, 4, r, e, p, 1'b0);
        exp_q.push_back(mk_exp(2, m2, 2));
        exp_q.push_back(mk_exp(3, m3, 3));
        exp_q.push_back(mk_exp(4, m4, 4));
        @(posedge clk_i);
        #1;
        if (r) begin
            edge_no = -1;
            fr2_t.delete();
            fr4_t.delete();
        end else begin
            edge_no++;
            if (fr2) fr2_t.push_back(edge_no);
            if (fr4) fr4_t.push_back(edge_no);
        end
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            case (x.inst)
                2: begin
                    check("d2 phase", int'(ph2), int'(x.ph));
                    check("d2 frame", int'(fr2), int'(x.fr));
                    check("d2 rst", int'(rs2), int'(x.rs));
                    check("d2 locked", int'(lk2), int'(x.lk));
                end
                3: begin
                    check("d3 phase", int'(ph3), int'(x.ph));
                    check("d3 frame", int'(fr3), int'(x.fr));
                    check("d3 rst", int'(rs3), int'(x.rs));
                    check("d3 locked", int'(lk3), int'(x.lk));
                end
                default: begin
                    check("d4 phase", int'(ph4), int'(x.ph));
                    check("d4 frame", int'(fr4), int'(x.fr));
                    check("d4 rst", int'(rs4), int'(x.rs));
                    check("d4 locked", int'(lk4), int'(x.lk));
                end
            endcase
        end
    endtask

    task automatic run(input int cycles, input bit e, input int p);
        for (int i = 0; i < cycles; i++) cycle(1'b0, e, p, 1'b0);
    endtask

    task automatic run_table();
        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].rst, vecs[i].en, vecs[i].psc, 1'b0);
            check($sformatf("tbl%0d phase", i), int'(ph2), int'(vecs[i].ph));
            check($sformatf("tbl%0d frame", i), int'(fr2), int'(vecs[i].fr));
            check($sformatf("tbl%0d rst", i), int'(rs2), int'(vecs[i].rs));
            check($sformatf("tbl%0d locked", i), int'(lk2), int'(vecs[i].lk));
        end
    endtask

    initial begin
        // 2-phase release sequence with psc=0: row 0 is the reset edge, rows 1..10 are edges 0..9.
        vecs[0]  = '{1'b1, 1'b1, 0, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 0, 2'b01, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 0, 2'b11, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 0, 2'b10, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 0, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 0, 2'b01, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 0, 2'b11, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 0, 2'b10, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 0, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 0, 2'b01, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 0, 2'b11, 1'b0, 1'b0, 1'b1};

        run_table();
        run(6, 1'b1, 0);

        // Four phases at psc=2: frame every 24 cycles.
        cycle(1'b1, 1'b1, 2, 1'b0);
        run(80, 1'b1, 2);
        if (fr4_t.size() >= 3) begin
            check("d4 frame period a", fr4_t[1] - fr4_t[0], 24);
            check("d4 frame period b", fr4_t[2] - fr4_t[1], 24);
        end else begin
            check("d4 frame count", fr4_t.size(), 3);
        end

        // Prescale 1 -> 3 mid-frame: 8-cycle frame, then 16-cycle frame.
        cycle(1'b1, 1'b1, 1, 1'b0);
        run(3, 1'b1, 1);
        run(40, 1'b1, 3);
        if (fr2_t.size() >= 3) begin
            check("psc change first frame", fr2_t[1] - fr2_t[0], 8);
            check("psc change next frame", fr2_t[2] - fr2_t[1], 16);
        end else begin
            check("psc change frame count", fr2_t.size(), 3);
        end

        // en_i low for 5 cycles mid-frame stretches that frame by exactly 5.
        cycle(1'b1, 1'b1, 0, 1'b0);
        run(6, 1'b1, 0);
        run(5, 1'b0, 0);
        run(20, 1'b1, 0);
        if (fr2_t.size() >= 3) begin
            check("en stall frame", fr2_t[2] - fr2_t[1], 9);
        end else begin
            check("en stall frame count", fr2_t.size(), 3);
        end

        // Illegal Johnson state on the 3-phase instance after release.
        cycle(1'b1, 1'b1, 0, 1'b0);
        run(20, 1'b1, 0);
        cycle(1'b0, 1'b1, 0, 1'b1);
        check("recover phase", int'(ph3), 0);
        check("recover locked", int'(lk3), 0);
        check("recover rst", int'(rs3), 0);
        cycle(1'b0, 1'b1, 0, 1'b0);
        check("relock locked", int'(lk3), 1);
        check("relock frame", int'(fr3), 1);
        run(10, 1'b1, 0);

        // Reset pulse during frame 5 replays the release sequence.
        cycle(1'b1, 1'b1, 0, 1'b0);
        run(22, 1'b1, 0);
        run_table();
        run(4, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/clk_phase_gen.md
# clk_phase_gen

Parametrised multiphase clock-enable generator that succeeds the two-phase (0°/90°) divider in the serializer clocking path. From a single clock it produces NUM_PHASES fully synchronous phase signals spaced one step apart, with a runtime-programmable prescaler. It also provides a frame strobe and a downstream reset that is held for a programmable number of frames and released aligned to the phase-0 rising edge. It replaces the latch/tristate divider with a flop-only, self-correcting Johnson counter.

## Interface
- NUM_PHASES, default 2, number of phase outputs (≥1); output period = 2·NUM_PHASES steps
- PRESCALE_W, default 4, width of the prescale field
- RST_HOLD, default 3, number of complete frame boundaries rst_o is held after rst_i falls (≥1)

- clk_i  input  1  sole clock; all logic on rising edge
- rst_i  input  1  reset, synchronous, active-high
- en_i  input  1  advance enable; low freezes all state
- prescale_i  input  PRESCALE_W  clk_i cycles per step minus 1; sampled only at reset and frame boundaries
- phase_o  output  NUM_PHASES  phase_o[k] lags phase_o[k-1] by one step
- frame_o  output  1  one-cycle pulse on the first cycle phase_o[0] is high
- rst_o  output  1  active-high downstream reset
- locked_o  output  1  high once rst_o released and counter legal

## Operation
- State: pcnt (PRESCALE_W), psc_q (PRESCALE_W), Johnson register j (NUM_PHASES), hold counter (enough bits for RST_HOLD), registered frame_o, rst_o, locked_o. phase_o = j directly (registered).
- tick = en_i && (pcnt == psc_q). On tick pcnt←0, else if en_i pcnt←pcnt+1.
- On tick: j ← {j[N-2:0], ~j[N-1]}. For N=2 sequence 00→01→11→10→00. For N=1: 0→1→0.
- Frame boundary = tick while j == 0. On it: psc_q ← prescale_i; frame_o ← 1 next cycle; otherwise frame_o ← 0.
- prescale_i changes between boundaries have no effect until the next boundary; period within a frame is constant.
- Hold: while rst_o high, each frame boundary increments hold counter; on the boundary where hold == RST_HOLD-1, rst_o ← 0 and locked_o ← 1 (same edge frame_o is set).
- Legality: legal j = thermometer from either end (0…01…1 or 1…10…0). If j illegal (only possible by upset/force), next edge regardless of en_i: j←0, pcnt←0, locked_o←0; rst_o unaffected. Counter resumes from 0 on following ticks; locked_o re-asserts at next frame boundary if rst_o already low.
- en_i low: pcnt, j, hold, psc_q frozen; frame_o ← 0; rst_o/locked_o hold.
- Reset (rst_i high at edge): j=0, pcnt=0, psc_q=prescale_i, frame_o=0, rst_o=1, locked_o=0, hold=0. Reset mid-operation overrides everything on that edge, including an illegal-state recovery or a tick.

## Timing
- Output period = 2·NUM_PHASES·(psc_q+1) clk_i cycles; duty 50%; phase step = psc_q+1 cycles.
- Edge 0 = first rising edge with rst_i low. With en_i high throughout, frame boundaries occur at edges F·2N·(psc+1)+psc, F = 0,1,2… (psc held constant).
- phase_o[0] and frame_o go high in the cycle after a boundary edge; latency zero between them.
- rst_o falls and locked_o rises in the cycle after the RST_HOLD-th boundary edge (F = RST_HOLD-1).
- Illegal-state recovery: 1 cycle.

## Test plan
- N=2, psc=0, RST_HOLD=3, en high: phase_o after edges 0..7 = 01,11,10,00,01,11,10,00; frame_o high after edges 0,4,8; rst_o falls and locked_o rises after edge 8.
- N=4, psc=2: each phase_o bit high 12 cycles/low 12, bit k delayed 3k cycles from bit 0; frame_o every 24 cycles.
- prescale_i changed 1→3 mid-frame: current frame keeps step 2 cycles; next frame, starting at boundary, steps every 4 cycles.
- en_i low for 5 cycles mid-frame: phase_o and pcnt frozen, frame_o stays 0, period extended by exactly 5 cycles.
- N=3, force j=101: next edge phase_o=000, locked_o=0; next frame boundary re-asserts locked_o with rst_o already 0.
- rst_i pulsed 1 cycle during frame 5: next edge phase_o=0, rst_o=1, locked_o=0; release sequence repeats exactly as first scenario.
